// File: rtl/crc64_pkg.sv
// Shared constants and state encoding for the serial CRC-64 (ECMA-182) parity generator.
package crc64_pkg;

  localparam logic [63:0] CRC64_POLY = 64'h42F0_E1EB_A9EA_3693;
  localparam logic [63:0] CRC64_INIT = 64'h0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    OUTPUT = 2'd2
  } crc64_state_e;

endpackage

// File: rtl/crc64_serial_step.sv
// One-bit CRC-64 LFSR step, purely combinational; the parity register lives in the caller.
module crc64_serial_step
  import crc64_pkg::*;
(
  input  logic        i_bit,
  input  logic [63:0] i_parity,
  output logic [63:0] o_parity
);

  logic fb;

  // POLY[0] is always set for a CRC generator, so bit 0 collapses to fb itself.
  always_comb begin
    fb       = i_bit ^ i_parity[63];
    o_parity = {i_parity[62:0], fb} ^ ({CRC64_POLY[63:1], 1'b0} & {64{fb}});
  end

endmodule

// File: rtl/crc64_serial_parity_gen.sv
// Serialises framed message words MSB-first through the CRC-64 step cell and
// presents the per-frame parity over a valid/ready handshake.
//
// state  | meaning
// IDLE   | ready for the next word; parity retained while a frame is active
// SHIFT  | one message bit per clock through the step cell
// OUTPUT | final frame parity presented until the consumer takes it
module crc64_serial_parity_gen
  import crc64_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int HASH_LENGTH = 64
) (
  input  logic                   i_clk,
  input  logic                   i_RESET,
  input  logic                   i_message_valid,
  input  logic [DATA_WIDTH-1:0]  i_message_data,
  input  logic                   i_message_last,
  output logic                   o_message_ready,
  output logic                   o_parity_valid,
  output logic [HASH_LENGTH-1:0] o_parity,
  input  logic                   i_parity_ready,
  output logic                   o_busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  crc64_state_e          state_q, state_d;
  logic [63:0]           parity_q, parity_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  active_q, active_d;
  logic [63:0]           step_parity;

  crc64_serial_step u_step (
    .i_bit    (shift_q[DATA_WIDTH-1]),
    .i_parity (parity_q),
    .o_parity (step_parity)
  );

  always_ff @(posedge i_clk or posedge i_RESET) begin
    if (i_RESET) begin
      state_q  <= IDLE;
      parity_q <= '0;
      shift_q  <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      parity_q <= parity_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    parity_d = parity_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    active_d = active_q;
    case (state_q)
      IDLE: begin
        if (i_message_valid) begin
          shift_d = i_message_data;
          last_d  = i_message_last;
          cnt_d   = '0;
          // Parity only restarts on the first word of a frame.
          if (!active_q) begin
            parity_d = CRC64_INIT;
            active_d = 1'b1;
          end
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        parity_d = step_parity;
        shift_d  = shift_q << 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = last_q ? OUTPUT : IDLE;
        end
      end
      OUTPUT: begin
        if (i_parity_ready) begin
          state_d  = IDLE;
          active_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_message_ready = (state_q == IDLE);
  assign o_parity_valid  = (state_q == OUTPUT);
  assign o_parity        = parity_q;
  assign o_busy          = active_q;

endmodule

// File: tb/tb_crc64_serial_parity_gen.sv
// Directed bench for crc64_serial_parity_gen: an 8-bit and a 1-bit build side by side.
module tb_crc64_serial_parity_gen;

  localparam logic [63:0] P_01   = 64'h42F0E1EBA9EA3693;
  localparam logic [63:0] P_CHK  = 64'h6C40DF5F0B497347;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        mv8 = 1'b0, ml8 = 1'b0, pr8 = 1'b0;
  logic [7:0]  md8 = '0;
  logic        mr8, pv8, busy8;
  logic [63:0] par8;

  logic        mv1 = 1'b0, ml1 = 1'b0, pr1 = 1'b0;
  logic [0:0]  md1 = '0;
  logic        mr1, pv1, busy1;
  logic [63:0] par1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  crc64_serial_parity_gen #(.DATA_WIDTH(8)) dut8 (
    .i_clk(clk), .i_RESET(rst),
    .i_message_valid(mv8), .i_message_data(md8), .i_message_last(ml8),
    .o_message_ready(mr8), .o_parity_valid(pv8), .o_parity(par8),
    .i_parity_ready(pr8), .o_busy(busy8)
  );

  crc64_serial_parity_gen #(.DATA_WIDTH(1)) dut1 (
    .i_clk(clk), .i_RESET(rst),
    .i_message_valid(mv1), .i_message_data(md1), .i_message_last(ml1),
    .o_message_ready(mr1), .o_parity_valid(pv1), .o_parity(par1),
    .i_parity_ready(pr1), .o_busy(busy1)
  );

  task automatic accept8(input logic [7:0] d, input logic l, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (mr8) begin ok = 1'b1; break; end
    end
    if (ok) begin
      mv8 = 1'b1; md8 = d; ml8 = l;
      @(posedge clk); #1;
      mv8 = 1'b0;
    end
  endtask

  task automatic accept1(input logic d, input logic l, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (mr1) begin ok = 1'b1; break; end
    end
    if (ok) begin
      mv1 = 1'b1; md1 = d; ml1 = l;
      @(posedge clk); #1;
      mv1 = 1'b0;
    end
  endtask

  // Counts rising edges from the current point until o_parity_valid is seen.
  task automatic wait_pv8(output bit ok, output int edges);
    ok = 1'b0; edges = 0;
    for (int k = 0; k < 300; k++) begin
      if (pv8) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic take8();
    pr8 = 1'b1;
    @(posedge clk); #1;
    pr8 = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (mr8 !== 1'b1) begin n_err++; $display("FAIL reset_ready8: got %b want 1", mr8); end
    n_cmp++; if (pv8 !== 1'b0) begin n_err++; $display("FAIL reset_pvalid8: got %b want 0", pv8); end
    n_cmp++; if (par8 !== 64'h0) begin n_err++; $display("FAIL reset_parity8: got %h want 0", par8); end
    n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL reset_busy8: got %b want 0", busy8); end
    n_cmp++; if (mr1 !== 1'b1 || pv1 !== 1'b0 || busy1 !== 1'b0 || par1 !== 64'h0) begin
      n_err++; $display("FAIL reset_dut1: ready %b pvalid %b busy %b parity %h want 1 0 0 0", mr1, pv1, busy1, par1);
    end
  endtask

  task automatic test_single_word();
    bit ok; int edges;
    accept8(8'h01, 1'b1, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL single_accept: timeout want accept"); end
    n_cmp++; if (busy8 !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy8); end
    wait_pv8(ok, edges);
    n_cmp++; if (!ok || edges != 8) begin n_err++; $display("FAIL single_latency: got %0d edges (ok=%0d) want 8", edges, ok); end
    n_cmp++; if (par8 !== P_01) begin n_err++; $display("FAIL single_parity: got %h want %h", par8, P_01); end
    take8();
    n_cmp++; if (pv8 !== 1'b0 || busy8 !== 1'b0 || mr8 !== 1'b1) begin
      n_err++; $display("FAIL single_handshake: pvalid %b busy %b ready %b want 0 0 1", pv8, busy8, mr8);
    end
  endtask

  task automatic test_check_string();
    bit ok; int edges;
    logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    for (int i = 0; i < 9; i++) begin
      accept8(msg[i], (i == 8), ok);
      n_cmp++; if (!ok || busy8 !== 1'b1) begin
        n_err++; $display("FAIL check_busy_word%0d: ok %0d busy %b want 1 1", i, ok, busy8);
      end
    end
    wait_pv8(ok, edges);
    n_cmp++; if (!ok || par8 !== P_CHK) begin n_err++; $display("FAIL check_parity: got %h (ok=%0d) want %h", par8, ok, P_CHK); end
    n_cmp++; if (busy8 !== 1'b1) begin n_err++; $display("FAIL check_busy_output: got %b want 1", busy8); end
    take8();
    n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL check_busy_after: got %b want 0", busy8); end
  endtask

  task automatic test_back_to_back();
    bit ok; int edges;
    accept8(8'h01, 1'b1, ok);
    wait_pv8(ok, edges);
    n_cmp++; if (!ok || par8 !== P_01) begin n_err++; $display("FAIL b2b_first: got %h (ok=%0d) want %h", par8, ok, P_01); end
    take8();
    accept8(8'h00, 1'b1, ok);
    wait_pv8(ok, edges);
    n_cmp++; if (!ok || par8 !== 64'h0) begin n_err++; $display("FAIL b2b_second: got %h (ok=%0d) want 0", par8, ok); end
    take8();
  endtask

  task automatic test_hold();
    bit ok; int edges;
    accept8(8'h01, 1'b1, ok);
    wait_pv8(ok, edges);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL hold_reach_output: timeout want pvalid"); end
    mv8 = 1'b1; md8 = 8'hAA; ml8 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (pv8 !== 1'b1 || par8 !== P_01 || mr8 !== 1'b0) begin
        n_err++; $display("FAIL hold_cycle%0d: pvalid %b parity %h ready %b want 1 %h 0", c, pv8, par8, mr8, P_01);
      end
    end
    mv8 = 1'b0;
    take8();
    n_cmp++; if (mr8 !== 1'b1 || pv8 !== 1'b0 || busy8 !== 1'b0) begin
      n_err++; $display("FAIL hold_release: ready %b pvalid %b busy %b want 1 0 0", mr8, pv8, busy8);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok; int edges; bit seen;
    accept8(8'hFF, 1'b0, ok);
    repeat (3) @(posedge clk);
    #2; rst = 1'b1; #2;
    n_cmp++; if (busy8 !== 1'b0 || mr8 !== 1'b1 || par8 !== 64'h0) begin
      n_err++; $display("FAIL midreset_values: busy %b ready %b parity %h want 0 1 0", busy8, mr8, par8);
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pv8) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_err++; $display("FAIL midreset_no_parity: pvalid seen 1 want 0"); end
    accept8(8'h01, 1'b1, ok);
    wait_pv8(ok, edges);
    n_cmp++; if (!ok || par8 !== P_01) begin n_err++; $display("FAIL midreset_next: got %h (ok=%0d) want %h", par8, ok, P_01); end
    take8();
  endtask

  task automatic test_width1();
    bit ok; bit got;
    logic bits [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) accept1(bits[i], (i == 2), ok);
    n_cmp++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL w1_busy: got %b want 1", busy1); end
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pv1) begin got = 1'b1; break; end
    end
    n_cmp++; if (!got || par1 !== P_01) begin n_err++; $display("FAIL w1_parity: got %h (valid=%0d) want %h", par1, got, P_01); end
    pr1 = 1'b1;
    @(posedge clk); #1;
    pr1 = 1'b0;
    n_cmp++; if (pv1 !== 1'b0 || busy1 !== 1'b0) begin n_err++; $display("FAIL w1_handshake: pvalid %b busy %b want 0 0", pv1, busy1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    test_reset();
    #21; rst = 1'b0;
    @(posedge clk); #1;
    test_single_word();
    test_check_string();
    test_back_to_back();
    test_hold();
    test_reset_midframe();
    test_width1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
